// File: rtl/sid_bus_master.sv
// sid_bus_master: queues SID register requests and replays them on the SID bus, one access per phi2 cycle
module sid_bus_master #(
  parameter int DEPTH   = 8,
  parameter int DELAY_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     phi2,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_read,
  input  logic [1:0]               req_cs,
  input  logic [4:0]               req_addr,
  input  logic [7:0]               req_data,
  input  logic [DELAY_W-1:0]       req_delay,
  output logic [4:0]               bus_addr,
  output logic [7:0]               bus_data,
  output logic                     bus_we,
  output logic [1:0]               bus_cs,
  input  logic [7:0]               bus_data_i,
  output logic                     rsp_valid,
  output logic [7:0]               rsp_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 16 + DELAY_W;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [1:0]         state;
  logic [DELAY_W-1:0] cnt;
  logic               phi2_prev;
  logic               fall, empty, push, go, defer, closing_read;
  logic               h_read;
  logic [1:0]         h_cs;
  logic [4:0]         h_addr;
  logic [7:0]         h_data;
  logic [DELAY_W-1:0] h_delay;

  assign {h_read, h_cs, h_addr, h_data, h_delay} = mem[rd_ptr];
  assign fall         = phi2_prev & ~phi2;
  assign empty        = level == '0;
  assign req_ready    = level != (AW+1)'(DEPTH);
  assign push         = req_valid & req_ready;
  assign go           = fall & ~empty & (state == WAIT ? cnt == DELAY_W'(1) : h_delay == '0);
  assign defer        = fall & ~empty & state != WAIT & h_delay != '0;
  assign closing_read = fall & state == ACCESS & ~bus_we;
  assign busy         = ~empty | state != IDLE;

  // request storage; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {req_read, req_cs, req_addr, req_data, req_delay};

  // phase tracking, FIFO bookkeeping, access sequencing and read capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phi2_prev <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      state     <= IDLE;
      cnt       <= '0;
      bus_addr  <= '0;
      bus_data  <= '0;
      bus_we    <= 1'b0;
      bus_cs    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      phi2_prev <= phi2;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (go) rd_ptr <= rd_ptr + AW'(1);
      level     <= level + (AW+1)'(push) - (AW+1)'(go);
      rsp_valid <= closing_read;
      if (closing_read) rsp_data <= bus_data_i;
      if (go) begin
        state    <= ACCESS;
        bus_addr <= h_addr;
        bus_data <= h_data;
        bus_cs   <= h_cs;
        bus_we   <= ~h_read;
      end else if (defer) begin
        state  <= WAIT;
        cnt    <= h_delay;
        bus_we <= 1'b0;
        bus_cs <= '0;
      end else if (fall && state == WAIT) begin
        cnt <= cnt - DELAY_W'(1);
      end else if (fall && state == ACCESS) begin
        state  <= IDLE;
        bus_we <= 1'b0;
        bus_cs <= '0;
      end
    end
  end
endmodule

// File: doc/sid_bus_master.md
Name: sid_bus_master

Overview:
- Bus initiator for the SID register interface.
- Queues register write/read requests from a host-side source (SID-dump player, debug UART bridge, MIDI mapper) and replays them onto the SID bus (addr, data, we, cs) in lock-step with phi2, exactly as a 6510 would.
- Sits in front of the dual-SID API block and shares its phi2 input, so each SID sees one access per phi2 cycle.
- Optional per-request delay, in phi2 cycles, allows timed register playback.

Parameters:
DEPTH, 8, request FIFO depth in entries; must be a power of 2, minimum 2.
DELAY_W, 16, width of the per-request delay field.

Ports:
clk  in  1  system clock, same domain as the SID API block.
reset_n  in  1  asynchronous active-low reset.
phi2  in  1  C64 phi2, synchronous to clk.
req_valid  in  1  request offered.
req_ready  out  1  FIFO can accept; equals not full.
req_read  in  1  1 = read access, 0 = write access.
req_cs  in  2  chip select: 2'b01 = SID #1, 2'b10 = SID #2.
req_addr  in  5  register address.
req_data  in  8  write data; ignored for reads.
req_delay  in  DELAY_W  idle phi2 cycles inserted before this access.
bus_addr  out  5  to SID addr.
bus_data  out  8  to SID data_i.
bus_we  out  1  to SID we.
bus_cs  out  2  to SID cs.
bus_data_i  in  8  from SID data_o.
rsp_valid  out  1  one-cycle pulse; read data valid.
rsp_data  out  8  read data; held until the next read completes.
level  out  $clog2(DEPTH)+1  FIFO occupancy.
busy  out  1  FIFO not empty, or state is not IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - Bus outputs: bus_we=0, bus_cs=0, bus_addr=0, bus_data=0.
  - Response outputs: rsp_valid=0, rsp_data=0.
  - FIFO emptied, level=0, state=IDLE, phi2_prev=0, delay counter=0.
  - Reset mid-access drops the bus immediately; all in-flight and queued requests are lost.
- Phase tick:
  - phi2_prev registers phi2.
  - fall = phi2_prev & ~phi2, i.e. one clk after the phi2 falling edge; this matches the SID core's PHI1 phase.
  - All state transitions below occur only on clk edges where fall=1, except FIFO push.
- FIFO:
  - Push when req_valid & req_ready.
  - Pop when the head is launched (transition into ACCESS).
  - Push and pop in the same cycle leave level unchanged.
  - Full: req_ready=0. Empty: no launch.
  - Pointers wrap modulo DEPTH.
- State machine:
  - IDLE, fall, FIFO non-empty:
    - head delay=0: launch head and go to ACCESS.
    - head delay=d>0: load cnt=d and go to WAIT; head stays in FIFO.
  - WAIT, fall:
    - cnt>1: cnt-=1.
    - cnt==1: launch head and go to ACCESS.
    - Result: exactly d full idle phi2 cycles before the access.
  - Launch:
    - Register head into bus_addr, bus_data, bus_cs and set bus_we = ~req_read; pop the head.
    - Bus values stay stable for one full phi2 cycle.
  - ACCESS, fall (end of access):
    - If the access was a read: rsp_data <= bus_data_i sampled on this edge, and rsp_valid=1 for exactly 1 clk.
    - Then one of:
      - next head present with delay=0: launch it on the same edge (back-to-back, bus never idle); go to ACCESS.
      - next head present with delay>0: drop the bus (we=0, cs=0; addr/data hold last values); load cnt; go to WAIT.
      - FIFO empty: drop the bus; go to IDLE.
- Requests with req_cs=2'b00 or 2'b11 are issued verbatim; the SID side defines their effect.
- phi2 stopped: no fall ticks, so state freezes with the bus held. Pushes continue until the FIFO is full.
- Throughput: at most 1 access per phi2 cycle.
- Latency from push into an empty IDLE block to bus drive: the next fall tick, plus 1 clk register delay.

Test Plan:
- Single write: push {write, cs=01, addr=0x18, data=0x0F, delay=0} → on the first fall tick bus shows addr=0x18, data=0x0F, we=1, cs=01 for exactly one phi2 period, then we=0/cs=0; level 1→0.
- Back-to-back: push 3 writes, delay=0, addr 0x00/0x01/0x04 → three consecutive phi2 cycles, bus_we never deasserted between them, order preserved.
- Delay: push a write with delay=3 → 3 phi2 cycles with we=0, access in the 4th; a delay=1 request with a FIFO waiting behind it inserts exactly 1 idle cycle.
- Read: push {read, cs=10, addr=0x1B}, drive bus_data_i=0xA5 during the access → bus_we=0, cs=10; rsp_valid pulses 1 clk with rsp_data=0xA5 at the closing fall tick.
- Full/wrap: push DEPTH+1 requests while phi2 is held high → req_ready=0 after DEPTH entries, level=DEPTH; release phi2 → all DEPTH entries drain in order; refill twice to exercise pointer wrap.
- Reset mid-operation: assert reset_n=0 during ACCESS with 2 entries queued → bus_we=0, bus_cs=0, level=0 immediately, without waiting for clk; after release no access occurs until a new push.
